// File: rtl/vga_fb_arbiter.sv
// Frame buffer arbiter: VGA scan-out reads on even active columns, camera writes
// drain from a small FIFO on odd columns and blanking. Optional: VGA_FB_PATTERN_EN.
module vga_fb_arbiter #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 17,
    parameter int FB_COLS     = 320,
    parameter int FB_ROWS     = 240,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int WBUF_DEPTH  = 4,
    parameter int RD_LATENCY  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
`ifdef VGA_FB_PATTERN_EN
    input  logic                  i_Pattern_Sel,
`endif
    input  logic [9:0]            i_Col_Count,
    input  logic [9:0]            i_Row_Count,
    input  logic                  i_Wr_Valid,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Ready,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic                  o_Mem_We,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic [DATA_WIDTH-1:0] o_Pix_Data,
    output logic                  o_Pix_Valid,
    output logic                  o_Overflow
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WBUF_DEPTH must be a power of 2 and at least 2");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("RD_LATENCY must be 1..3");
    end
    if (FB_ROWS * 2 != ACTIVE_ROWS || FB_COLS * 2 != ACTIVE_COLS) begin : g_bad_geometry
        $error("frame buffer must be exactly half the active resolution");
    end

    typedef enum logic [1:0] {
        S_BLANK,
        S_RD,
        S_WR
    } state_t;

    state_t state_q, state_d;

    logic                  active;
    logic                  pattern_on;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  empty;

    logic [ADDR_WIDTH-1:0] fifo_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic [RD_LATENCY-1:0] act_pipe;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [DATA_WIDTH-1:0] hold_q;

`ifdef VGA_FB_PATTERN_EN
    assign pattern_on = i_Pattern_Sel;
`else
    assign pattern_on = 1'b0;
`endif

    assign active = (32'(i_Col_Count) < 32'(ACTIVE_COLS)) &&
                    (32'(i_Row_Count) < 32'(ACTIVE_ROWS));

    assign rd_addr = ADDR_WIDTH'(i_Row_Count >> 1) * ADDR_WIDTH'(FB_COLS)
                   + ADDR_WIDTH'(i_Col_Count >> 1);

    assign full       = (count == CNT_W'(WBUF_DEPTH));
    assign empty      = (count == '0);
    assign o_Wr_Ready = !full;
    assign push       = i_Wr_Valid && !full;

    // Slot ownership follows the live counts with no hysteresis.
    always_comb begin
        state_d = S_BLANK;
        pop     = 1'b0;
        if (active) begin
            state_d = (!i_Col_Count[0] && !pattern_on) ? S_RD : S_WR;
        end
        if (state_d != S_RD && !empty) begin
            pop = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_Wr_Addr;
            fifo_data[wr_ptr] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_Wr_Valid && full) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    // RAM port: read address in read slots, FIFO head on a pop, otherwise held.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Mem_Addr  <= '0;
            o_Mem_Wdata <= '0;
            o_Mem_We    <= 1'b0;
        end else begin
            o_Mem_We <= pop;
            if (state_d == S_RD) begin
                o_Mem_Addr <= rd_addr;
            end else if (pop) begin
                o_Mem_Addr  <= fifo_addr[rd_ptr];
                o_Mem_Wdata <= fifo_data[rd_ptr];
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            act_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            act_pipe[0] <= (state_q != S_BLANK);
            rd_pipe[0]  <= (state_q == S_RD);
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end

`ifdef VGA_FB_PATTERN_EN
    logic [2:0]            bar_idx;
    logic [DATA_WIDTH-1:0] bar_colour;
    logic                  pat_q;
    logic [DATA_WIDTH-1:0] colour_q;
    logic [RD_LATENCY-1:0] pat_pipe;
    logic [DATA_WIDTH-1:0] colour_pipe [RD_LATENCY];

    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(i_Col_Count) >= 32'(i * 80)) begin
                bar_idx = 3'(i);
            end
        end
        bar_colour = DATA_WIDTH'({{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}});
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pat_q    <= 1'b0;
            colour_q <= '0;
            pat_pipe <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                colour_pipe[i] <= '0;
            end
        end else begin
            pat_q          <= pattern_on;
            colour_q       <= bar_colour;
            pat_pipe[0]    <= pat_q;
            colour_pipe[0] <= colour_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pat_pipe[i]    <= pat_pipe[i-1];
                colour_pipe[i] <= colour_pipe[i-1];
            end
        end
    end
`endif

    // The odd column re-uses the pixel captured on the preceding even column.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hold_q <= '0;
        end else if (act_pipe[RD_LATENCY-1] && rd_pipe[RD_LATENCY-1]) begin
            hold_q <= i_Mem_Rdata;
        end
    end

    assign o_Pix_Valid = act_pipe[RD_LATENCY-1];

    always_comb begin
        o_Pix_Data = '0;
        if (act_pipe[RD_LATENCY-1]) begin
`ifdef VGA_FB_PATTERN_EN
            if (pat_pipe[RD_LATENCY-1]) begin
                o_Pix_Data = colour_pipe[RD_LATENCY-1];
            end else
`endif
            if (rd_pipe[RD_LATENCY-1]) begin
                o_Pix_Data = i_Mem_Rdata;
            end else begin
                o_Pix_Data = hold_q;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, queue-based reference model, vector table
// and hand sequences for reset, overflow, blanking and mid-line reset.
module tb_vga_fb_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    col, row;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          overflow;
`ifdef VGA_FB_PATTERN_EN
    logic          pat_sel = 1'b0;
`endif

    always #20 clk = ~clk;

    vga_fb_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WBUF_DEPTH(DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
`ifdef VGA_FB_PATTERN_EN
        .i_Pattern_Sel(pat_sel),
`endif
        .i_Col_Count (col),
        .i_Row_Count (row),
        .i_Wr_Valid  (wr_valid),
        .i_Wr_Addr   (wr_addr),
        .i_Wr_Data   (wr_data),
        .o_Wr_Ready  (wr_ready),
        .o_Mem_Addr  (mem_addr),
        .o_Mem_We    (mem_we),
        .o_Mem_Wdata (mem_wdata),
        .i_Mem_Rdata (mem_rdata),
        .o_Pix_Data  (pix_data),
        .o_Pix_Valid (pix_valid),
        .o_Overflow  (overflow)
    );

    // Single-port RAM: data appears LAT cycles after the address is presented.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rq  [LAT];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rq[0] <= ram[mem_addr];
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign mem_rdata = rq[LAT-1];

    // Reference model state
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    wr_t           q[$];
    wr_t           pend;
    bit            pend_v;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    bit            ovf_m;
    bit            act_h [8];
    logic [DW-1:0] pix_h [8];
    logic [DW-1:0] hold_m;
    int            cyc;
    int            n_checks;
    int            n_fail;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend_v    = 0;
        exp_addr  = '0;
        exp_wdata = '0;
        ovf_m     = 0;
        hold_m    = '0;
        for (int i = 0; i < 8; i++) begin
            act_h[i] = 0;
            pix_h[i] = '0;
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_we",    mem_we,    0);
        chk("rst_addr",  mem_addr,  0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", wr_ready,  1);
        chk("rst_pix",   pix_data,  0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_ovf",   overflow,  0);
    endtask

    // One pixel clock: drive, compare at the falling edge, advance the model.
    task automatic step(input logic [9:0] c, input logic [9:0] r, input bit wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit        act, rd, full, nxt_v;
        wr_t       nxt;
        int        hi;
        int        fb;
        col = c; row = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        @(negedge clk);
        hi = (cyc - 1 - LAT) % 8;
        chk("mem_we",    mem_we,    pend_v);
        chk("mem_addr",  mem_addr,  exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("wr_ready",  wr_ready,  q.size() < DEPTH);
        chk("overflow",  overflow,  ovf_m);
        chk("pix_valid", pix_valid, act_h[hi]);
        chk("pix_data",  pix_data,  act_h[hi] ? pix_h[hi] : '0);

        if (pend_v) ref_mem[pend.a] = pend.d;
        act  = (c < 640) && (r < 480);
        rd   = act && !c[0];
        full = (q.size() == DEPTH);
        fb   = (r / 2) * 320 + (c / 2);
        nxt_v = 0;
        if (rd) begin
            exp_addr = AW'(fb);
            hold_m   = ref_mem[AW'(fb)];
        end else if (q.size() > 0) begin
            nxt       = q.pop_front();
            nxt_v     = 1;
            exp_addr  = nxt.a;
            exp_wdata = nxt.d;
        end
        if (wv) begin
            if (full) ovf_m = 1;
            else      q.push_back('{wa, wd});
        end
        act_h[cyc % 8] = act;
        pix_h[cyc % 8] = hold_m;
        pend   = nxt;
        pend_v = nxt_v;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values();
        model_clear();
        col = 10'd700; wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 3;
    endtask

    typedef struct {
        logic [9:0]    c;
        logic [9:0]    r;
        logic [AW-1:0] a;
    } vec_t;

    vec_t tbl [8];
    bit   saw_not_ready;
    int   n_we;

    initial begin
        tbl[0] = '{10'd0,   10'd0,   17'd0};
        tbl[1] = '{10'd638, 10'd479, 17'd76799};
        tbl[2] = '{10'd2,   10'd1,   17'd1};
        tbl[3] = '{10'd2,   10'd2,   17'd321};
        tbl[4] = '{10'd300, 10'd100, 17'd16150};
        tbl[5] = '{10'd10,  10'd0,   17'd5};
        tbl[6] = '{10'd700, 10'd0,   17'd5};
        tbl[7] = '{10'd20,  10'd600, 17'd5};

        n_checks = 0; n_fail = 0; cyc = 8;
        rst_n = 1'b0; col = 10'd700; row = 10'd0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read address vectors, no writes pending
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].c, tbl[i].r, 0, '0, '0);
            chk("tbl_addr", mem_addr, tbl[i].a);
            chk("tbl_we",   mem_we,   0);
        end
        for (int c = 0; c < 6; c++) step(10'(700 + c), 10'd0, 0, '0, '0);

        // Preloaded pixel appears 3 cycles after col 10 and is held for 2
        ram[5] = 12'hABC; ref_mem[5] = 12'hABC;
        for (int c = 8; c <= 13; c++) begin
            step(10'(c), 10'd0, 0, '0, '0);
            if (c == 12 || c == 13) begin
                chk("preload_pix",   pix_data,  12'hABC);
                chk("preload_valid", pix_valid, 1);
            end
        end
        for (int c = 14; c < 24; c++) step(10'(c), 10'd0, 0, '0, '0);

        // Back-to-back writes from an even active column
        for (int i = 0; i < 4; i++) begin
            step(10'(20 + i), 10'd2, 1, AW'(100 + i), DW'($urandom));
            if (i == 1) begin
                chk("b2b_first_we",   mem_we,   1);
                chk("b2b_first_addr", mem_addr, 100);
            end
        end
        for (int c = 24; c < 40; c++) step(10'(c), 10'd2, 0, '0, '0);
        chk("b2b_ovf", overflow, 0);

        // Horizontal blanking, one write per cycle
        saw_not_ready = 0;
        for (int i = 0; i < 8; i++) begin
            if (!wr_ready) saw_not_ready = 1;
            step(10'(640 + i), 10'd3, 1, AW'(200 + i), DW'($urandom));
        end
        for (int c = 648; c < 660; c++) step(10'(c), 10'd3, 0, '0, '0);
        chk("hblank_ready_held", saw_not_ready, 0);

        // Random traffic over full lines, including frame and row wrap
        foreach (tbl[k]) ;
        for (int li = 0; li < 6; li++) begin
            int rr;
            case (li)
                0: rr = 4;   1: rr = 5;   2: rr = 479;
                3: rr = 480; 4: rr = 524; default: rr = 0;
            endcase
            for (int c = 0; c < 800; c++)
                step(10'(c), 10'(rr), ($urandom % 3) == 0,
                     AW'($urandom_range(0, 76799)), DW'($urandom));
        end

        // Sustained writes in active video overrun the FIFO
        saw_not_ready = 0;
        for (int c = 0; c < 12; c++) begin
            step(10'(c), 10'd30, 1, AW'(300 + c), DW'($urandom));
            if (!wr_ready) saw_not_ready = 1;
        end
        for (int c = 12; c < 800; c++) step(10'(c), 10'd30, 0, '0, '0);
        chk("burst_ready_dropped", saw_not_ready, 1);
        chk("burst_ovf_sticky",    overflow,      1);

        // Reset mid-line with three entries queued
        for (int c = 0; c < 5; c++) step(10'(c), 10'd40, 1, AW'(400 + c), DW'($urandom));
        chk("pre_reset_depth", q.size(), 3);
        do_reset();
        n_we = 0;
        for (int c = 700; c < 800; c++) begin
            step(10'(c), 10'd40, 0, '0, '0);
            if (mem_we) n_we++;
        end
        chk("stale_writes", n_we, 0);
        for (int c = 0; c < 30; c++) step(10'(c), 10'd41, 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
